// File: rtl/lcd_frame_fetch.sv
// lcd_frame_fetch: framebuffer prefetcher for the 800x480 LCD timing stage.
// Issues Avalon-MM burst reads from SDRAM into a show-ahead FIFO. The FIFO
// space for a burst is reserved when the burst is issued, so the FIFO
// cannot overflow. Every data_request pulse restarts the fetch at frame_base.
// Optional build macro LCD_FETCH_UNDERFLOW_EN adds the underflow_cnt and
// underflow_sticky outputs.
module lcd_frame_fetch #(
    parameter int ADDR_W      = 32,
    parameter int FIFO_AW     = 9,
    parameter int BURST_LEN   = 32,
    parameter int FRAME_WORDS = 384000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              data_request,
    input  logic              lcd_read,
    output logic [23:0]       lcd_readdata,
    output logic              no_data_available,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [FIFO_AW:0]  avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
`ifdef LCD_FETCH_UNDERFLOW_EN
    ,
    output logic [15:0]       underflow_cnt,
    output logic              underflow_sticky
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int WL_W  = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DATA, S_RESTART} state_t;

    state_t            state, state_nxt;
    logic [23:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_count, beats_out, next_bc;
    logic [CW:0]       free_words;
    logic [ADDR_W-1:0] cur_addr;
    logic [WL_W-1:0]   words_left;
    logic              restart_pend;
    logic              empty, push, pop, flush, accept, can_issue, start_burst;
    logic              unused_rdata_hi;

    // Only the low 24 bits of each memory word carry the pixel.
    assign unused_rdata_hi = ^avm_readdata[31:24];

    assign empty             = (fifo_count == '0);
    assign no_data_available = empty;
    assign lcd_readdata      = empty ? 24'd0 : mem[rd_ptr];
    assign pop               = lcd_read && !empty;
    // Beats of a burst accepted before a restart request are dropped.
    assign push              = avm_readdatavalid && !restart_pend;
    assign flush             = (state == S_RESTART);
    assign accept            = (state == S_ISSUE) && avm_read && !avm_waitrequest;

    // Burst size is the smaller of BURST_LEN and what is left of the frame.
    assign next_bc    = (int'(words_left) >= BURST_LEN) ? CW'(BURST_LEN) : CW'(words_left);
    assign free_words = (CW+1)'(DEPTH) - {1'b0, fifo_count} - {1'b0, beats_out};
    assign can_issue  = (words_left != '0) && (free_words >= {1'b0, next_bc});
    assign start_burst = (state == S_IDLE) && !restart_pend && can_issue;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a pending restart wins over a new burst in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (restart_pend)   state_nxt = S_RESTART;
                else if (can_issue) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) state_nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (beats_out == '0 || (avm_readdatavalid && beats_out == CW'(1)))
                    state_nxt = S_IDLE;
            end
            S_RESTART: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Avalon request registers, burst bookkeeping and frame position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            beats_out      <= '0;
            cur_addr       <= '0;
            words_left     <= '0;
        end else begin
            if (start_burst) begin
                avm_read       <= 1'b1;
                avm_address    <= cur_addr;
                avm_burstcount <= next_bc;
            end else if (accept) begin
                avm_read <= 1'b0;
            end

            if (accept)
                beats_out <= avm_burstcount;
            else if (avm_readdatavalid && beats_out != '0)
                beats_out <= beats_out - CW'(1);

            if (flush) begin
                cur_addr   <= frame_base;
                words_left <= WL_W'(FRAME_WORDS);
            end else if (accept) begin
                cur_addr   <= cur_addr + (ADDR_W'(avm_burstcount) << 2);
                words_left <= words_left - WL_W'(avm_burstcount);
            end
        end
    end

    // Restart request latch; a request in the RESTART cycle re-arms it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          restart_pend <= 1'b0;
        else if (data_request) restart_pend <= 1'b1;
        else if (flush)        restart_pend <= 1'b0;
    end

    // FIFO pointers and occupancy; flush returns everything to empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Pixel storage, left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avm_readdata[23:0];
    end

`ifdef LCD_FETCH_UNDERFLOW_EN
    // Count reads against an empty FIFO; cleared at each frame request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_cnt    <= '0;
            underflow_sticky <= 1'b0;
        end else if (data_request) begin
            underflow_cnt    <= '0;
            underflow_sticky <= 1'b0;
        end else if (lcd_read && empty) begin
            if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
            underflow_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_frame_fetch.sv
// Directed bench for lcd_frame_fetch. Instance 0 uses the default frame
// size; instance 1 uses a 100-word frame. Both share the stimulus, and each
// has its own burst memory model that returns word address as data.
module tb_lcd_frame_fetch;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       frame_base;
    logic              data_request;
    logic              lcd_read;
    logic              waitreq;
    int                lat;

    logic [1:0][23:0]  lrd;
    logic [1:0]        nda;
    logic [1:0][31:0]  aaddr;
    logic [1:0]        aread;
    logic [1:0][9:0]   abc;
    logic [1:0][31:0]  rdata;
    logic [1:0]        rdv;
`ifdef LCD_FETCH_UNDERFLOW_EN
    logic [1:0][15:0]  ucnt;
    logic [1:0]        usticky;
`endif

    int total = 0;
    int bad   = 0;

    int          rem [2];
    int          dly [2];
    logic [31:0] wptr_m [2];
    int          nb [2];
    logic [31:0] blog_addr [2][256];
    logic [9:0]  blog_bc [2][256];

    always #5 clk = ~clk;

    lcd_frame_fetch u_dut (
        .clk(clk), .reset_n(reset_n), .frame_base(frame_base), .data_request(data_request),
        .lcd_read(lcd_read), .lcd_readdata(lrd[0]), .no_data_available(nda[0]),
        .avm_address(aaddr[0]), .avm_read(aread[0]), .avm_burstcount(abc[0]),
        .avm_waitrequest(waitreq), .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0])
`ifdef LCD_FETCH_UNDERFLOW_EN
        , .underflow_cnt(ucnt[0]), .underflow_sticky(usticky[0])
`endif
    );

    lcd_frame_fetch #(.FRAME_WORDS(100)) u_small (
        .clk(clk), .reset_n(reset_n), .frame_base(frame_base), .data_request(data_request),
        .lcd_read(lcd_read), .lcd_readdata(lrd[1]), .no_data_available(nda[1]),
        .avm_address(aaddr[1]), .avm_read(aread[1]), .avm_burstcount(abc[1]),
        .avm_waitrequest(waitreq), .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1])
`ifdef LCD_FETCH_UNDERFLOW_EN
        , .underflow_cnt(ucnt[1]), .underflow_sticky(usticky[1])
`endif
    );

    // Burst memory model: 'lat' idle cycles after acceptance, then one beat per cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 2; g++) begin
                rem[g]    <= 0;
                dly[g]    <= 0;
                wptr_m[g] <= '0;
                nb[g]     <= 0;
            end
            rdv   <= '0;
            rdata <= '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                rdv[g] <= 1'b0;
                if (rem[g] > 0) begin
                    if (dly[g] > 0) dly[g] <= dly[g] - 1;
                    else begin
                        rdv[g]    <= 1'b1;
                        rdata[g]  <= wptr_m[g];
                        wptr_m[g] <= wptr_m[g] + 1;
                        rem[g]    <= rem[g] - 1;
                    end
                end
                if (aread[g] && !waitreq) begin
                    rem[g]    <= int'(abc[g]);
                    dly[g]    <= lat;
                    wptr_m[g] <= aaddr[g] >> 2;
                    blog_addr[g][nb[g] % 256] <= aaddr[g];
                    blog_bc[g][nb[g] % 256]   <= abc[g];
                    nb[g]     <= nb[g] + 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; data_request = 1'b0; lcd_read = 1'b0;
        waitreq = 1'b0; lat = 0; frame_base = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick;
    endtask

    task automatic pulse_req(input logic [31:0] base);
        frame_base   = base;
        data_request = 1'b1;
        tick;
        data_request = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (nda[0] !== 1'b1) begin bad++; $display("FAIL reset_nda got=%b want=1", nda[0]); end
        total++; if (lrd[0] !== 24'd0) begin bad++; $display("FAIL reset_lrd got=%h want=0", lrd[0]); end
        total++; if (aread[0] !== 1'b0) begin bad++; $display("FAIL reset_read got=%b want=0", aread[0]); end
        total++; if (aaddr[0] !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", aaddr[0]); end
        total++; if (abc[0] !== 10'd0) begin bad++; $display("FAIL reset_bc got=%0d want=0", abc[0]); end
        repeat (20) tick;
        total++; if (nb[0] !== 0) begin bad++; $display("FAIL reset_idle bursts got=%0d want=0", nb[0]); end
    endtask

    task automatic test_fill_stall;
        do_reset;
        pulse_req(32'h0010_0000);
        for (int k = 0; k < 50 && !aread[0]; k++) tick;
        total++; if (aaddr[0] !== 32'h0010_0000 || abc[0] !== 10'd32 || aread[0] !== 1'b1) begin
            bad++; $display("FAIL fill_first_burst got addr=%h bc=%0d rd=%b want addr=00100000 bc=32 rd=1", aaddr[0], abc[0], aread[0]); end
        for (int k = 0; k < 100 && nb[0] < 2; k++) tick;
        total++; if (nb[0] < 2 || blog_addr[0][1] !== 32'h0010_0080) begin
            bad++; $display("FAIL fill_second_burst got n=%0d addr=%h want addr=00100080", nb[0], blog_addr[0][1]); end
        repeat (1000) tick;
        total++; if (nb[0] !== 16) begin bad++; $display("FAIL fill_stall bursts got=%0d want=16", nb[0]); end
        lcd_read = 1'b1;
        for (int i = 0; i < 32; i++) begin
            total++; if (nda[0] !== 1'b0 || lrd[0] !== 24'h040000 + 24'(i)) begin
                bad++; $display("FAIL fill_pop%0d got=%h nda=%b want=%h", i, lrd[0], nda[0], 24'h040000 + 24'(i)); end
            tick;
        end
        lcd_read = 1'b0;
        repeat (100) tick;
        total++; if (nb[0] !== 17) begin bad++; $display("FAIL fill_refill bursts got=%0d want=17", nb[0]); end
    endtask

    task automatic test_frame_end;
        int exp_bc [4] = '{32, 32, 32, 4};
        do_reset;
        pulse_req(32'h0010_0000);
        repeat (400) tick;
        total++; if (nb[1] !== 4) begin bad++; $display("FAIL end_bursts got=%0d want=4", nb[1]); end
        for (int i = 0; i < 4; i++) begin
            total++; if (int'(blog_bc[1][i]) !== exp_bc[i] || blog_addr[1][i] !== 32'h0010_0000 + 32'(i * 128)) begin
                bad++; $display("FAIL end_burst%0d got bc=%0d addr=%h want bc=%0d addr=%h", i, blog_bc[1][i],
                                blog_addr[1][i], exp_bc[i], 32'h0010_0000 + 32'(i * 128)); end
        end
        lcd_read = 1'b1;
        for (int i = 0; i < 100; i++) begin
            total++; if (nda[1] !== 1'b0 || lrd[1] !== 24'h040000 + 24'(i)) begin
                bad++; $display("FAIL end_pop%0d got=%h nda=%b want=%h", i, lrd[1], nda[1], 24'h040000 + 24'(i)); end
            tick;
        end
        total++; if (nda[1] !== 1'b1 || lrd[1] !== 24'd0) begin
            bad++; $display("FAIL end_empty got nda=%b data=%h want nda=1 data=0", nda[1], lrd[1]); end
        repeat (5) tick;
        total++; if (nda[1] !== 1'b1 || nb[1] !== 4) begin
            bad++; $display("FAIL end_extra_pops got nda=%b bursts=%0d want nda=1 bursts=4", nda[1], nb[1]); end
        lcd_read = 1'b0;
    endtask

    task automatic test_waitrequest;
        logic [31:0] a0;
        logic [9:0]  b0;
        do_reset;
        waitreq = 1'b1;
        pulse_req(32'h0010_0000);
        for (int k = 0; k < 50 && !aread[0]; k++) tick;
        a0 = aaddr[0];
        b0 = abc[0];
        for (int i = 0; i < 5; i++) begin
            total++; if (aread[0] !== 1'b1 || aaddr[0] !== 32'h0010_0000 || abc[0] !== 10'd32) begin
                bad++; $display("FAIL wait_hold%0d got rd=%b addr=%h bc=%0d want rd=1 addr=00100000 bc=32", i, aread[0], aaddr[0], abc[0]); end
            tick;
        end
        total++; if (aaddr[0] !== a0 || abc[0] !== b0 || nb[0] !== 0) begin
            bad++; $display("FAIL wait_stable got addr=%h bc=%0d n=%0d want addr=%h bc=%0d n=0", aaddr[0], abc[0], nb[0], a0, b0); end
        waitreq = 1'b0;
        tick;
        total++; if (aread[0] !== 1'b0 || nb[0] !== 1) begin
            bad++; $display("FAIL wait_accept got rd=%b bursts=%0d want rd=0 bursts=1", aread[0], nb[0]); end
    endtask

    task automatic test_restart_mid_burst;
        int beats;
        do_reset;
        pulse_req(32'h0010_0000);
        beats = 0;
        for (int k = 0; k < 100 && beats < 20; k++) begin
            tick;
            if (rdv[0]) beats++;
        end
        frame_base   = 32'h0020_0000;
        data_request = 1'b1;
        tick;
        data_request = 1'b0;
        for (int k = 0; k < 100 && nb[0] < 2; k++) tick;
        total++; if (nb[0] !== 2 || blog_addr[0][1] !== 32'h0020_0000 || blog_bc[0][1] !== 10'd32) begin
            bad++; $display("FAIL restart_burst got n=%0d addr=%h bc=%0d want n=2 addr=00200000 bc=32",
                            nb[0], blog_addr[0][1], blog_bc[0][1]); end
        total++; if (nda[0] !== 1'b1) begin bad++; $display("FAIL restart_flush got nda=%b want 1", nda[0]); end
        for (int k = 0; k < 20 && nda[0]; k++) tick;
        total++; if (nda[0] !== 1'b0 || lrd[0] !== 24'h080000) begin
            bad++; $display("FAIL restart_first_pixel got=%h nda=%b want=080000", lrd[0], nda[0]); end
    endtask

    task automatic test_full_rate;
        do_reset;
        lat = 10;
        pulse_req(32'h0000_0400);
        repeat (1200) tick;
        lcd_read = 1'b1;
        for (int i = 0; i < 300; i++) begin
            total++; if (nda[0] !== 1'b0 || lrd[0] !== 24'h000100 + 24'(i)) begin
                bad++; $display("FAIL rate_pix%0d got=%h nda=%b want=%h", i, lrd[0], nda[0], 24'h000100 + 24'(i)); end
            tick;
        end
        lcd_read = 1'b0;
    endtask

`ifdef LCD_FETCH_UNDERFLOW_EN
    task automatic test_underflow;
        do_reset;
        total++; if (ucnt[0] !== 16'd0 || usticky[0] !== 1'b0) begin
            bad++; $display("FAIL uf_reset got cnt=%0d st=%b want 0 0", ucnt[0], usticky[0]); end
        lcd_read = 1'b1;
        repeat (7) tick;
        lcd_read = 1'b0;
        tick;
        total++; if (ucnt[0] !== 16'd7 || usticky[0] !== 1'b1) begin
            bad++; $display("FAIL uf_count got cnt=%0d st=%b want 7 1", ucnt[0], usticky[0]); end
        pulse_req(32'h0010_0000);
        total++; if (ucnt[0] !== 16'd0 || usticky[0] !== 1'b0) begin
            bad++; $display("FAIL uf_clear got cnt=%0d st=%b want 0 0", ucnt[0], usticky[0]); end
    endtask
`endif

    initial begin
        test_reset;
        test_fill_stall;
        test_frame_end;
        test_waitrequest;
        test_restart_mid_burst;
        test_full_rate;
`ifdef LCD_FETCH_UNDERFLOW_EN
        test_underflow;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_frame_fetch.md
Name: lcd_frame_fetch

Overview:
- Upstream feeder for the 800x480 LCD timing stage.
- Reads the framebuffer from SDRAM over an Avalon-MM burst read master and buffers pixels in a show-ahead FIFO.
- Serves the timing stage through lcd_read / lcd_readdata / no_data_available.
- Restarts from the frame base address on every data_request pulse, which the timing stage issues once per frame during vertical blanking.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW = 512 words.
- BURST_LEN, 32, maximum words per Avalon burst; power of two, at most depth/2.
- FRAME_WORDS, 384000, 32-bit words fetched per frame (800*480).

Ports:
- clk  in  1  pixel/system clock
- reset_n  in  1  asynchronous active-low reset
- frame_base  in  ADDR_W  framebuffer byte address; sampled on restart
- data_request  in  1  one-cycle pulse that starts the next-frame prefetch
- lcd_read  in  1  pops the FIFO head this cycle
- lcd_readdata  out  24  FIFO head pixel {R,G,B}, taken from memory word bits [23:0]
- no_data_available  out  1  FIFO empty
- avm_address  out  ADDR_W  burst start byte address
- avm_read  out  1  read request
- avm_burstcount  out  FIFO_AW+1  words in the current burst
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data beat valid

Behaviour:
- Reset: FIFO empty; no_data_available=1; lcd_readdata=0; avm_read=0; avm_address=0; avm_burstcount=0; state IDLE; words_left=0; restart_pend=0.
- FIFO: show-ahead.
  - lcd_readdata is always the head word, combinational from the read pointer; it is valid whenever no_data_available=0.
  - Pop on lcd_read && !empty. lcd_read while empty is ignored; pointers are unchanged.
  - Push on avm_readdatavalid when not discarding.
  - Simultaneous push and pop both take effect; the count is unchanged.
  - Overflow is impossible by construction: space is reserved at burst issue.
- Reserved space: free = depth - fifo_count - beats_outstanding. A burst is issued only when free >= avm_burstcount.
- State machine:
  - IDLE:
    - restart_pend → RESTART.
    - words_left>0 and free >= min(BURST_LEN, words_left) → ISSUE. On entry, drive avm_address=cur_addr, avm_burstcount=min(BURST_LEN, words_left), avm_read=1.
  - ISSUE:
    - Hold avm_read, avm_address and avm_burstcount stable while avm_waitrequest=1.
    - When the request is accepted (avm_read && !avm_waitrequest): avm_read=0, beats_outstanding=burstcount, cur_addr += 4*burstcount, words_left -= burstcount, then → WAIT_DATA.
  - WAIT_DATA:
    - Decrement beats_outstanding on each avm_readdatavalid.
    - When it reaches 0 → IDLE.
  - RESTART (one cycle):
    - Flush the FIFO (pointers to 0).
    - cur_addr=frame_base, words_left=FRAME_WORDS, restart_pend=0.
    - → IDLE.
- data_request:
  - Sets restart_pend in any state.
  - A burst that was already accepted is never aborted. Its remaining beats are discarded (not pushed), and RESTART is taken once beats_outstanding=0.
  - A request held in ISSUE completes its handshake first and is then treated like an accepted burst.
  - data_request in the same cycle as the RESTART state re-arms restart_pend; the restart then repeats.
- End of frame: when words_left=0 the block stays in IDLE. Further lcd_read with an empty FIFO yields no_data_available=1.
- Address arithmetic: modulo 2**ADDR_W wrap, with no special handling.
- Latency: first word visible at lcd_readdata one cycle after the first accepted avm_readdatavalid of a frame.
- Reset mid-burst: everything returns to reset values immediately. The interconnect is assumed to be reset by the same reset_n.

Optional Feature:
- Macro: LCD_FETCH_UNDERFLOW_EN.
- When defined:
  - Adds output underflow_cnt (16 bits) and output underflow_sticky (1 bit).
  - underflow_cnt increments, saturating at 16'hFFFF, on each cycle with lcd_read=1 and FIFO empty.
  - underflow_sticky sets on the first such cycle.
  - Both clear on data_request and on reset.
- When undefined: neither port exists and the logic is absent. All other behaviour is identical.

Test Plan:
1. Reset, then data_request with frame_base=32'h0010_0000 and a zero-wait memory model. → First burst at address 0x0010_0000, burstcount=32. Second burst at 0x0010_0080. The FIFO fills to 512 and further bursts stall until there is space.
2. FRAME_WORDS=100, BURST_LEN=32 (override). → Bursts of 32, 32, 32, then 4, after which there are no more reads. After 100 pops with lcd_read held high, no_data_available=1 and further pops are ignored.
3. avm_waitrequest held high for 5 cycles at issue. → avm_read, avm_address and avm_burstcount stay stable for all 5 cycles and exactly one burst is accepted.
4. data_request pulsed during WAIT_DATA with 20 of 32 beats returned. → The remaining 12 beats are not pushed, the FIFO is flushed, and the next burst starts at the new frame_base.
5. Continuous lcd_read at full rate with a memory model at 1 beat per cycle and a 10-cycle initial latency. → After the initial fill, the pixel sequence matches memory words 0..N-1 in order, with no_data_available=0 throughout.
6. (LCD_FETCH_UNDERFLOW_EN defined) 7 lcd_read cycles with the FIFO empty. → underflow_cnt=7 and underflow_sticky=1; both return to 0 on the next data_request.
